bch_32_bits_enc_s: RTL



---
 rtl/bch_enc_pkg.sv | 32 +++
 rtl/bch15_7_lfsr_enc.sv | 26 ++
 rtl/bch_32_bits_enc_s.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bch_enc_pkg.sv
// Shared constants, state encoding and the LFSR step function for the
// BCH(15,7) 32-bit word encoder.
package bch_enc_pkg;

  localparam int BCH_N       = 15;  // codeword length of a full block
  localparam int BCH_K       = 7;   // message length of a full block
  localparam int BCH_P       = 8;   // parity bits per block
  localparam int NUM_BLOCKS  = 5;   // four full blocks plus one shortened block
  localparam int SHORT_K     = 4;   // message bits actually carried by the last block
  localparam int DATA_W      = 32;
  localparam int CW_W        = 4 * BCH_N + SHORT_K + BCH_P;  // 72
  localparam int CNT_W       = 3;

  // g(x) = x^8 + x^7 + x^6 + x^4 + 1 with the x^8 term implied.
  localparam logic [BCH_P-1:0] BCH_GEN_MASK = 8'hD1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // One division step, message MSB first. After BCH_K steps the register
  // holds the remainder of m(x)*x^8 mod g(x), i.e. the block parity.
  function automatic logic [BCH_P-1:0] lfsr_step(input logic [BCH_P-1:0] r,
                                                 input logic             d);
    logic fb;
    fb = d ^ r[BCH_P-1];
    return {r[BCH_P-2:0], 1'b0} ^ (fb ? BCH_GEN_MASK : '0);
  endfunction

endpackage

// File: rtl/bch15_7_lfsr_enc.sv
// Bit-serial BCH(15,7) parity generator: one LFSR step per enabled cycle.
module bch15_7_lfsr_enc
  import bch_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [BCH_P-1:0] parity
);

  // Parity register: synchronous clear wins over a step.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= '0;
    end else if (clr) begin
      parity <= '0;
    end else if (en) begin
      parity <= lfsr_step(parity, bit_in);
    end
  end

endmodule

// File: rtl/bch_32_bits_enc_s.sv
// Systematic BCH(15,7) encoder for 32-bit words: four full 7-bit blocks and
// one shortened 4-bit block are encoded in parallel by five bit-serial LFSRs,
// and the 72-bit codeword is offered on a valid/ready handshake.
module bch_32_bits_enc_s
  import bch_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CW_W-1:0]   codeword_out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t state, next_state;

  logic [CNT_W-1:0]                   cnt;
  logic [NUM_BLOCKS-1:0][BCH_K-1:0]   msg;
  logic [DATA_W-1:0]                  data_q;
  logic [NUM_BLOCKS-1:0][BCH_P-1:0]   parity;
  logic [NUM_BLOCKS-1:0][BCH_P-1:0]   parity_final;
  logic                               load;
  logic                               step;
  logic                               last;

  // Next-state and handshake decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered upstream.
        in_ready = ~rst;
        if (in_valid) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_W'(BCH_K - 1)) begin
          last       = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Step counter: cleared on acceptance, counts 0..6 through SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || last) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Message shift registers (MSB feeds the LFSR) and the captured data word.
  // NOTE: these small registers are reset so a discarded word leaves no
  // stale content behind; a large RAM-backed buffer would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg    <= '0;
      data_q <= '0;
    end else if (load) begin
      data_q <= data_in;
      msg[0] <= data_in[6:0];
      msg[1] <= data_in[13:7];
      msg[2] <= data_in[20:14];
      msg[3] <= data_in[27:21];
      msg[4] <= {{(BCH_K - SHORT_K){1'b0}}, data_in[31:28]};
    end else if (step) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        msg[i] <= {msg[i][BCH_K-2:0], 1'b0};
      end
    end
  end

  // Five parallel parity generators, one per block.
  for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_lfsr
    bch15_7_lfsr_enc u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .clr    (load),
      .en     (step),
      .bit_in (msg[g][BCH_K-1]),
      .parity (parity[g])
    );
  end

  // The codeword is captured on the same edge as the seventh LFSR step, so
  // the final parity is the registered value advanced by one step.
  always_comb begin
    parity_final = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      parity_final[i] = lfsr_step(parity[i], msg[i][BCH_K-1]);
    end
  end

  // Codeword register: changes only on the SHIFT->DONE edge and on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codeword_out <= '0;
    end else if (last) begin
      codeword_out <= {data_q[31:28], parity_final[4],
                       data_q[27:21], parity_final[3],
                       data_q[20:14], parity_final[2],
                       data_q[13:7],  parity_final[1],
                       data_q[6:0],   parity_final[0]};
    end
  end

endmodule
